// File: rtl/game_pkg.sv
// Shared types for the game move path: move codes, scheduler states and move sources.
package game_pkg;

  typedef enum logic [2:0] {
    MV_NONE   = 3'd0,
    MV_LEFT   = 3'd1,
    MV_RIGHT  = 3'd2,
    MV_ROTATE = 3'd3,
    MV_DOWN   = 3'd4,
    MV_DROP   = 3'd5
  } move_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_HALT      = 2'd3
  } sched_state_t;

  typedef enum logic {
    SRC_GRAV = 1'b0,
    SRC_USER = 1'b1
  } move_src_t;

  // Only LEFT..DROP are executable; anything else is dropped at grant time.
  function automatic logic move_is_legal(input logic [2:0] code);
    return (code >= 3'(MV_LEFT)) && (code <= 3'(MV_DROP));
  endfunction

endpackage

// File: rtl/game_level_tracker.sv
// Cleared-line accounting: saturating line total, per-level accumulator and level-step pulse.
module game_level_tracker #(
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 15
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        en,
  input  logic        lines_valid_i,
  input  logic [2:0]  lines_i,
  output logic [3:0]  level_o,
  output logic        level_changed_o,
  output logic [15:0] total_lines_o
);

  // Accumulator never exceeds LINES_PER_LEVEL-1+4 since one report adds at most 4.
  localparam int ACC_W = $clog2(LINES_PER_LEVEL + 5);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [16:0]      total_sum;

  assign acc_sum   = acc + ACC_W'(lines_i);
  assign total_sum = {1'b0, total_lines_o} + 17'(lines_i);

  always_ff @(posedge clk) begin
    if (srst) begin
      acc             <= '0;
      level_o         <= '0;
      level_changed_o <= 1'b0;
      total_lines_o   <= '0;
    end else begin
      level_changed_o <= 1'b0;
      if (en && lines_valid_i) begin
        total_lines_o <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
        if (acc_sum >= ACC_W'(LINES_PER_LEVEL)) begin
          acc <= acc_sum - ACC_W'(LINES_PER_LEVEL);
          if (level_o < 4'(MAX_LEVEL)) begin
            level_o         <= level_o + 4'd1;
            level_changed_o <= 1'b1;
          end
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

endmodule

// File: rtl/game_move_sched.sv
// Merges gravity ticks and user moves into one move stream, one move in flight at a time.
// Optional GAME_MOVE_SCHED_PAUSE_EN adds pause_i, which freezes new issues and intake.
module game_move_sched
  import game_pkg::*;
#(
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 15,
  parameter int USER_BURST_MAX  = 2
) (
  input  logic        clk,
  input  logic        srst,
`ifdef GAME_MOVE_SCHED_PAUSE_EN
  input  logic        pause_i,
`endif
  input  logic        sys_event_i,
  input  logic        user_move_valid_i,
  input  logic [2:0]  user_move_i,
  output logic        user_ready_o,
  output logic        move_valid_o,
  output logic [2:0]  move_o,
  output logic        move_src_o,
  input  logic        core_ready_i,
  input  logic        core_done_i,
  input  logic        lines_valid_i,
  input  logic [2:0]  lines_i,
  input  logic        game_over_i,
  output logic [3:0]  level_o,
  output logic        level_changed_o,
  output logic [15:0] total_lines_o,
  output logic        halted_o
);

  localparam logic [1:0] IDLE      = ST_IDLE;
  localparam logic [1:0] ISSUE     = ST_ISSUE;
  localparam logic [1:0] WAIT_DONE = ST_WAIT_DONE;
  localparam logic [1:0] HALT      = ST_HALT;

  localparam int            BW        = (USER_BURST_MAX < 1) ? 1 : $clog2(USER_BURST_MAX + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(USER_BURST_MAX);

  logic [1:0]    state;
  logic          grav_pend, grav_age;
  logic          buf_full, buf_age;
  logic [2:0]    buf_code;
  logic [BW-1:0] burst_cnt;

  logic pause, handshake, hs_user, hs_grav, tick, user_load;
  logic grav_ok, user_ok, arb_go, pick_grav, pick_user, drop_user;

`ifdef GAME_MOVE_SCHED_PAUSE_EN
  assign pause = pause_i;
`else
  assign pause = 1'b0;
`endif

  // Game over pre-empts a handshake in the same cycle, so nothing is consumed then.
  assign handshake = (state == ISSUE) && core_ready_i && !game_over_i;
  assign hs_user   = handshake && move_src_o;
  assign hs_grav   = handshake && !move_src_o;

  // A user move arriving while the buffered one is being consumed refills the buffer.
  assign user_ready_o = !pause && (!buf_full || hs_user);
  assign user_load    = user_move_valid_i && user_ready_o;
  assign tick         = sys_event_i && !pause && (state != HALT);

  // Fresh entries age one cycle before they can win, giving capture-to-issue of two edges.
  assign grav_ok   = grav_pend && grav_age;
  assign user_ok   = buf_full && buf_age;
  assign arb_go    = (state == IDLE) && !pause && !game_over_i;
  assign pick_grav = arb_go && grav_ok && (!user_ok || (burst_cnt == BURST_MAX));
  assign pick_user = arb_go && user_ok && !pick_grav;
  assign drop_user = pick_user && !move_is_legal(buf_code);

  always_ff @(posedge clk) begin
    if (srst) begin
      grav_pend <= 1'b0;
      grav_age  <= 1'b0;
      buf_full  <= 1'b0;
      buf_age   <= 1'b0;
      buf_code  <= '0;
    end else begin
      grav_age <= grav_pend;
      buf_age  <= buf_full;
      // New arrivals win over the consume-clear so a same-cycle entry is retained.
      if (tick)         grav_pend <= 1'b1;
      else if (hs_grav) grav_pend <= 1'b0;
      if (user_load) begin
        buf_full <= 1'b1;
        buf_code <= user_move_i;
      end else if (hs_user || drop_user) begin
        buf_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst)                                 burst_cnt <= '0;
    else if (!grav_pend || pick_grav)         burst_cnt <= '0;
    else if (pick_user && !drop_user && burst_cnt != BURST_MAX)
                                              burst_cnt <= burst_cnt + BW'(1);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state        <= IDLE;
      move_valid_o <= 1'b0;
      move_o       <= '0;
      move_src_o   <= 1'b0;
    end else if (game_over_i) begin
      state        <= HALT;
      move_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_grav) begin
            state        <= ISSUE;
            move_valid_o <= 1'b1;
            move_o       <= MV_DOWN;
            move_src_o   <= SRC_GRAV;
          end else if (pick_user && !drop_user) begin
            state        <= ISSUE;
            move_valid_o <= 1'b1;
            move_o       <= buf_code;
            move_src_o   <= SRC_USER;
          end
        end
        ISSUE: begin
          if (core_ready_i) begin
            state        <= WAIT_DONE;
            move_valid_o <= 1'b0;
          end
        end
        WAIT_DONE: if (core_done_i) state <= IDLE;
        default:   state <= HALT;
      endcase
    end
  end

  assign halted_o = (state == HALT);

  game_level_tracker #(
    .LINES_PER_LEVEL (LINES_PER_LEVEL),
    .MAX_LEVEL       (MAX_LEVEL)
  ) u_level (
    .clk             (clk),
    .srst            (srst),
    .en              (state != HALT),
    .lines_valid_i   (lines_valid_i),
    .lines_i         (lines_i),
    .level_o         (level_o),
    .level_changed_o (level_changed_o),
    .total_lines_o   (total_lines_o)
  );

endmodule

// File: tb/tb_game_move_sched.sv
// Bench for game_move_sched: directed scenarios plus randomized issue-order and level checks.
module tb_game_move_sched;

  logic        clk = 1'b0;
  logic        srst;
  logic        sys_event_i;
  logic        user_move_valid_i;
  logic [2:0]  user_move_i;
  logic        user_ready_o;
  logic        move_valid_o;
  logic [2:0]  move_o;
  logic        move_src_o;
  logic        core_ready_i;
  logic        core_done_i;
  logic        lines_valid_i;
  logic [2:0]  lines_i;
  logic        game_over_i;
  logic [3:0]  level_o;
  logic        level_changed_o;
  logic [15:0] total_lines_o;
  logic        halted_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Core model controls and the log of accepted moves ({src, code}).
  logic       core_rdy_cmd = 1'b1;
  int         done_lat = 3;
  int         core_cd = 0;
  logic [3:0] obs_q[$];

  always #5 clk = ~clk;

  game_move_sched dut (
    .clk               (clk),
    .srst              (srst),
    .sys_event_i       (sys_event_i),
    .user_move_valid_i (user_move_valid_i),
    .user_move_i       (user_move_i),
    .user_ready_o      (user_ready_o),
    .move_valid_o      (move_valid_o),
    .move_o            (move_o),
    .move_src_o        (move_src_o),
    .core_ready_i      (core_ready_i),
    .core_done_i       (core_done_i),
    .lines_valid_i     (lines_valid_i),
    .lines_i           (lines_i),
    .game_over_i       (game_over_i),
    .level_o           (level_o),
    .level_changed_o   (level_changed_o),
    .total_lines_o     (total_lines_o),
    .halted_o          (halted_o)
  );

  // Core responder: accepts per core_rdy_cmd, pulses done done_lat cycles after a handshake.
  initial begin
    core_ready_i = 1'b0;
    core_done_i  = 1'b0;
    forever begin
      @(negedge clk);
      core_ready_i = core_rdy_cmd;
      core_done_i  = 1'b0;
      if (srst) core_cd = 0;
      else if (core_cd > 0) begin
        core_cd = core_cd - 1;
        if (core_cd == 0) core_done_i = 1'b1;
      end
      if (!srst && move_valid_o && core_ready_i) begin
        obs_q.push_back({move_src_o, move_o});
        core_cd = done_lat;
      end
    end
  end

  task automatic do_reset();
    srst = 1'b1; sys_event_i = 1'b0; user_move_valid_i = 1'b0; user_move_i = 3'd0;
    lines_valid_i = 1'b0; lines_i = 3'd0; game_over_i = 1'b0;
    repeat (2) @(negedge clk);
    srst = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (move_valid_o !== 1'b0)     begin n_bad++; $display("FAIL reset_valid: got %b want 0", move_valid_o); end
    n_cmp++; if (move_o !== 3'd0)           begin n_bad++; $display("FAIL reset_move: got %0d want 0", move_o); end
    n_cmp++; if (move_src_o !== 1'b0)       begin n_bad++; $display("FAIL reset_src: got %b want 0", move_src_o); end
    n_cmp++; if (user_ready_o !== 1'b1)     begin n_bad++; $display("FAIL reset_ready: got %b want 1", user_ready_o); end
    n_cmp++; if (level_o !== 4'd0)          begin n_bad++; $display("FAIL reset_level: got %0d want 0", level_o); end
    n_cmp++; if (level_changed_o !== 1'b0)  begin n_bad++; $display("FAIL reset_lchg: got %b want 0", level_changed_o); end
    n_cmp++; if (total_lines_o !== 16'd0)   begin n_bad++; $display("FAIL reset_total: got %0d want 0", total_lines_o); end
    n_cmp++; if (halted_o !== 1'b0)         begin n_bad++; $display("FAIL reset_halted: got %b want 0", halted_o); end
  endtask

  task automatic test_latency();
    do_reset();
    sys_event_i = 1'b1;
    @(negedge clk); sys_event_i = 1'b0;
    n_cmp++; if (move_valid_o !== 1'b0) begin n_bad++; $display("FAIL lat_grav_k: got %b want 0", move_valid_o); end
    @(negedge clk);
    n_cmp++; if (move_valid_o !== 1'b0) begin n_bad++; $display("FAIL lat_grav_k1: got %b want 0", move_valid_o); end
    @(negedge clk);
    n_cmp++; if ({move_valid_o, move_src_o, move_o} !== 5'b1_0_100)
      begin n_bad++; $display("FAIL lat_grav_k2: got v=%b s=%b m=%0d want v=1 s=0 m=4", move_valid_o, move_src_o, move_o); end
    @(negedge clk);
    n_cmp++; if (move_valid_o !== 1'b0) begin n_bad++; $display("FAIL lat_grav_after_hs: got %b want 0", move_valid_o); end
    wait_cyc(6);
    user_move_valid_i = 1'b1; user_move_i = 3'd2;
    @(negedge clk); user_move_valid_i = 1'b0;
    n_cmp++; if (move_valid_o !== 1'b0) begin n_bad++; $display("FAIL lat_user_k: got %b want 0", move_valid_o); end
    @(negedge clk);
    n_cmp++; if (move_valid_o !== 1'b0) begin n_bad++; $display("FAIL lat_user_k1: got %b want 0", move_valid_o); end
    @(negedge clk);
    n_cmp++; if ({move_valid_o, move_src_o, move_o} !== 5'b1_1_010)
      begin n_bad++; $display("FAIL lat_user_k2: got v=%b s=%b m=%0d want v=1 s=1 m=2", move_valid_o, move_src_o, move_o); end
    wait_cyc(8);
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_q[4];
    int base, acc, guard;
    exp_q = '{4'b1_001, 4'b1_001, 4'b0_100, 4'b1_001};
    do_reset();
    base = obs_q.size(); acc = 0; guard = 0;
    sys_event_i = 1'b1; user_move_i = 3'd1;
    while (obs_q.size() < base + 4 && guard < 150) begin
      user_move_valid_i = (acc < 3);
      #1;
      if (user_move_valid_i && user_ready_o) acc++;
      @(negedge clk);
      sys_event_i = 1'b0;
      guard++;
    end
    user_move_valid_i = 1'b0;
    wait_cyc(12);
    n_cmp++; if (obs_q.size() !== base + 4)
      begin n_bad++; $display("FAIL burst_count: got %0d moves want 4", obs_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (base + i >= obs_q.size()) begin n_bad++; $display("FAIL burst_order[%0d]: got none want %h", i, exp_q[i]); end
      else if (obs_q[base+i] !== exp_q[i])
        begin n_bad++; $display("FAIL burst_order[%0d]: got %h want %h", i, obs_q[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_collapse();
    int base, guard;
    do_reset();
    done_lat = 14;
    base = obs_q.size(); guard = 0;
    user_move_valid_i = 1'b1; user_move_i = 3'd5;
    @(negedge clk); user_move_valid_i = 1'b0;
    while (obs_q.size() == base && guard < 20) begin @(negedge clk); guard++; end
    wait_cyc(2);
    for (int i = 0; i < 5; i++) begin
      sys_event_i = 1'b1; @(negedge clk);
      sys_event_i = 1'b0; @(negedge clk);
    end
    wait_cyc(40);
    done_lat = 3;
    n_cmp++; if (obs_q.size() !== base + 2)
      begin n_bad++; $display("FAIL collapse_count: got %0d moves want 2", obs_q.size() - base); end
    n_cmp++;
    if (obs_q.size() < base + 2) begin n_bad++; $display("FAIL collapse_grav: got none want 4"); end
    else if (obs_q[base+1] !== 4'b0_100) begin n_bad++; $display("FAIL collapse_grav: got %h want 4", obs_q[base+1]); end
  endtask

  task automatic test_invalid_codes();
    logic [2:0] bad_codes[3];
    int base;
    bad_codes = '{3'd0, 3'd6, 3'd7};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      base = obs_q.size();
      user_move_valid_i = 1'b1; user_move_i = bad_codes[i];
      @(negedge clk); user_move_valid_i = 1'b0;
      wait_cyc(8);
      n_cmp++; if (obs_q.size() !== base)
        begin n_bad++; $display("FAIL invalid_issued[%0d]: got %0d moves want 0", bad_codes[i], obs_q.size() - base); end
      n_cmp++; if (user_ready_o !== 1'b1)
        begin n_bad++; $display("FAIL invalid_ready[%0d]: got %b want 1", bad_codes[i], user_ready_o); end
    end
  endtask

  // Each step is one isolated event; expected issue list follows the source rules directly.
  task automatic test_random_moves();
    logic [3:0] exp_q[$];
    int base, kind;
    logic [2:0] code;
    logic legal;
    do_reset();
    base = obs_q.size();
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 2);
      code = 3'($urandom_range(0, 7));
      legal = (code >= 3'd1) && (code <= 3'd5);
      done_lat = $urandom_range(1, 6);
      if (kind != 0) begin user_move_valid_i = 1'b1; user_move_i = code; end
      if (kind != 1) sys_event_i = 1'b1;
      if (kind != 0 && legal) exp_q.push_back({1'b1, code});
      if (kind != 1) exp_q.push_back(4'b0_100);
      @(negedge clk);
      user_move_valid_i = 1'b0; sys_event_i = 1'b0;
      wait_cyc(30);
    end
    done_lat = 3;
    n_cmp++; if (obs_q.size() - base !== exp_q.size())
      begin n_bad++; $display("FAIL rand_count: got %0d moves want %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (base + i >= obs_q.size()) begin n_bad++; $display("FAIL rand_move[%0d]: got none want %h", i, exp_q[i]); end
      else if (obs_q[base+i] !== exp_q[i])
        begin n_bad++; $display("FAIL rand_move[%0d]: got %h want %h", i, obs_q[base+i], exp_q[i]); end
    end
  endtask

  task automatic test_levels();
    int pulses;
    do_reset();
    lines_valid_i = 1'b1; lines_i = 3'd4;
    @(negedge clk);
    n_cmp++; if ({level_o, level_changed_o, total_lines_o} !== {4'd0, 1'b0, 16'd4})
      begin n_bad++; $display("FAIL lvl_a: got l=%0d p=%b t=%0d want 0 0 4", level_o, level_changed_o, total_lines_o); end
    @(negedge clk); lines_i = 3'd2;
    n_cmp++; if ({level_o, level_changed_o, total_lines_o} !== {4'd0, 1'b0, 16'd8})
      begin n_bad++; $display("FAIL lvl_b: got l=%0d p=%b t=%0d want 0 0 8", level_o, level_changed_o, total_lines_o); end
    @(negedge clk); lines_valid_i = 1'b0;
    n_cmp++; if ({level_o, level_changed_o, total_lines_o} !== {4'd1, 1'b1, 16'd10})
      begin n_bad++; $display("FAIL lvl_c: got l=%0d p=%b t=%0d want 1 1 10", level_o, level_changed_o, total_lines_o); end
    @(negedge clk);
    n_cmp++; if (level_changed_o !== 1'b0) begin n_bad++; $display("FAIL lvl_pulse_len: got %b want 0", level_changed_o); end
    // 40 reports of 4 take the total from 10 to 170: steps at 20..150 give 14 pulses.
    pulses = 0; lines_valid_i = 1'b1; lines_i = 3'd4;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (level_changed_o === 1'b1) pulses++;
    end
    lines_valid_i = 1'b0;
    n_cmp++; if (pulses !== 14) begin n_bad++; $display("FAIL lvl_to_max_pulses: got %0d want 14", pulses); end
    n_cmp++; if (level_o !== 4'd15) begin n_bad++; $display("FAIL lvl_max: got %0d want 15", level_o); end
    // Saturation: 16400 more reports of 4 overflow 16 bits; level stays pinned with no pulses.
    pulses = 0; lines_valid_i = 1'b1;
    for (int i = 0; i < 16400; i++) begin
      @(negedge clk);
      if (level_changed_o === 1'b1) pulses++;
    end
    lines_valid_i = 1'b0;
    @(negedge clk);
    if (level_changed_o === 1'b1) pulses++;
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL lvl_sat_pulses: got %0d want 0", pulses); end
    n_cmp++; if (total_lines_o !== 16'hFFFF) begin n_bad++; $display("FAIL lvl_total_sat: got %0d want 65535", total_lines_o); end
    n_cmp++; if (level_o !== 4'd15) begin n_bad++; $display("FAIL lvl_sat_level: got %0d want 15", level_o); end
  endtask

  task automatic test_random_levels();
    int sum, prev_lvl, exp_lvl, exp_tot, l;
    do_reset();
    sum = 0;
    for (int it = 0; it < 80; it++) begin
      l = $urandom_range(0, 4);
      wait_cyc($urandom_range(0, 2));
      lines_valid_i = 1'b1; lines_i = 3'(l);
      @(negedge clk); lines_valid_i = 1'b0;
      prev_lvl = (sum / 10 > 15) ? 15 : sum / 10;
      sum += l;
      exp_lvl = (sum / 10 > 15) ? 15 : sum / 10;
      exp_tot = (sum > 65535) ? 65535 : sum;
      n_cmp++; if (level_o !== 4'(exp_lvl))
        begin n_bad++; $display("FAIL rlvl_level[%0d]: got %0d want %0d", it, level_o, exp_lvl); end
      n_cmp++; if (level_changed_o !== (exp_lvl != prev_lvl))
        begin n_bad++; $display("FAIL rlvl_pulse[%0d]: got %b want %b", it, level_changed_o, exp_lvl != prev_lvl); end
      n_cmp++; if (total_lines_o !== 16'(exp_tot))
        begin n_bad++; $display("FAIL rlvl_total[%0d]: got %0d want %0d", it, total_lines_o, exp_tot); end
    end
  endtask

  task automatic test_halt();
    int base, guard;
    do_reset();
    core_rdy_cmd = 1'b0;
    @(negedge clk);
    base = obs_q.size(); guard = 0;
    sys_event_i = 1'b1;
    @(negedge clk); sys_event_i = 1'b0;
    while (move_valid_o !== 1'b1 && guard < 10) begin @(negedge clk); guard++; end
    n_cmp++; if (move_valid_o !== 1'b1) begin n_bad++; $display("FAIL halt_pre_valid: got %b want 1", move_valid_o); end
    game_over_i = 1'b1;
    @(negedge clk); game_over_i = 1'b0;
    n_cmp++; if (move_valid_o !== 1'b0) begin n_bad++; $display("FAIL halt_valid: got %b want 0", move_valid_o); end
    n_cmp++; if (halted_o !== 1'b1)     begin n_bad++; $display("FAIL halt_flag: got %b want 1", halted_o); end
    core_rdy_cmd = 1'b1;
    sys_event_i = 1'b1; lines_valid_i = 1'b1; lines_i = 3'd3;
    @(negedge clk);
    sys_event_i = 1'b0; lines_valid_i = 1'b0;
    wait_cyc(10);
    n_cmp++; if (move_valid_o !== 1'b0)   begin n_bad++; $display("FAIL halt_hold_valid: got %b want 0", move_valid_o); end
    n_cmp++; if (halted_o !== 1'b1)       begin n_bad++; $display("FAIL halt_hold_flag: got %b want 1", halted_o); end
    n_cmp++; if (total_lines_o !== 16'd0) begin n_bad++; $display("FAIL halt_lines: got %0d want 0", total_lines_o); end
    n_cmp++; if (obs_q.size() !== base)   begin n_bad++; $display("FAIL halt_issued: got %0d moves want 0", obs_q.size() - base); end
    do_reset();
    n_cmp++; if (halted_o !== 1'b0)       begin n_bad++; $display("FAIL halt_exit: got %b want 0", halted_o); end
  endtask

  task automatic test_srst_mid();
    int base, guard;
    do_reset();
    done_lat = 12;
    lines_valid_i = 1'b1; lines_i = 3'd4;
    @(negedge clk); lines_valid_i = 1'b0;
    base = obs_q.size(); guard = 0;
    user_move_valid_i = 1'b1; user_move_i = 3'd1;
    @(negedge clk); user_move_valid_i = 1'b0;
    while (obs_q.size() == base && guard < 20) begin @(negedge clk); guard++; end
    wait_cyc(2);
    user_move_valid_i = 1'b1; user_move_i = 3'd2;
    @(negedge clk); user_move_valid_i = 1'b0;
    n_cmp++; if (user_ready_o !== 1'b0) begin n_bad++; $display("FAIL srst_pre_full: got %b want 0", user_ready_o); end
    srst = 1'b1;
    @(negedge clk); srst = 1'b0;
    n_cmp++; if ({move_valid_o, move_o, move_src_o} !== 5'd0)
      begin n_bad++; $display("FAIL srst_move: got v=%b m=%0d s=%b want 0 0 0", move_valid_o, move_o, move_src_o); end
    n_cmp++; if (user_ready_o !== 1'b1) begin n_bad++; $display("FAIL srst_ready: got %b want 1", user_ready_o); end
    n_cmp++; if ({level_o, level_changed_o, total_lines_o, halted_o} !== 22'd0)
      begin n_bad++; $display("FAIL srst_level: got l=%0d p=%b t=%0d h=%b want 0", level_o, level_changed_o, total_lines_o, halted_o); end
    wait_cyc(25);
    done_lat = 3;
    n_cmp++; if (obs_q.size() !== base + 1)
      begin n_bad++; $display("FAIL srst_flushed: got %0d moves want 1", obs_q.size() - base); end
  endtask

  initial begin
    srst = 1'b1; sys_event_i = 1'b0; user_move_valid_i = 1'b0; user_move_i = 3'd0;
    lines_valid_i = 1'b0; lines_i = 3'd0; game_over_i = 1'b0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_collapse();
    test_invalid_codes();
    test_random_moves();
    test_levels();
    test_random_levels();
    test_halt();
    test_srst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
